// File: rtl/morse_decoder.sv
// Morse symbol collector and decoder feeding a 4-entry first-word-fall-through FIFO.
// A word gap pushes any pending character, then a space one cycle later.
module morse_decoder #(
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot,
    input  logic       dash,
    input  logic       interchar,
    input  logic       interword,
    input  logic       rd_en,
    output logic [7:0] char_out,
    output logic       empty,
    output logic       full,
    output logic [2:0] count,
    output logic       overflow,
    output logic [2:0] sym_len
);
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ERR} state_t;

    state_t     r_state;
    logic [4:0] r_pattern;
    logic [2:0] r_sym_len;
    logic       r_last_space;
    logic       r_pend_space;
    logic [7:0] r_mem [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       r_overflow;

    logic       w_iw, w_ic, w_sym, w_char_push, w_push, w_pop, w_wr;
    logic [7:0] w_decoded, w_push_data;

    // Gap pulses are blind during the pending-space cycle; symbols are not.
    assign w_iw        = interword & ~r_pend_space;
    assign w_ic        = interchar & ~interword & ~r_pend_space;
    assign w_sym       = (dot | dash) & ~w_iw & ~w_ic;
    assign w_char_push = (w_iw | w_ic) & (r_state != S_IDLE);
    assign w_push      = r_pend_space | w_char_push;
    assign w_push_data = r_pend_space ? 8'h20 :
                         (r_state == S_ERR) ? UNKNOWN_CHAR : w_decoded;
    assign w_pop       = rd_en & (r_count != 3'd0);
    assign w_wr        = w_push & ((r_count != DEPTH) | w_pop);

    always_comb begin
        w_decoded = UNKNOWN_CHAR;
        case ({r_sym_len, r_pattern})
            8'b001_00000: w_decoded = "E";
            8'b001_00001: w_decoded = "T";
            8'b010_00000: w_decoded = "I";
            8'b010_00001: w_decoded = "A";
            8'b010_00010: w_decoded = "N";
            8'b010_00011: w_decoded = "M";
            8'b011_00000: w_decoded = "S";
            8'b011_00001: w_decoded = "U";
            8'b011_00010: w_decoded = "R";
            8'b011_00011: w_decoded = "W";
            8'b011_00100: w_decoded = "D";
            8'b011_00101: w_decoded = "K";
            8'b011_00110: w_decoded = "G";
            8'b011_00111: w_decoded = "O";
            8'b100_00000: w_decoded = "H";
            8'b100_00001: w_decoded = "V";
            8'b100_00010: w_decoded = "F";
            8'b100_00100: w_decoded = "L";
            8'b100_00110: w_decoded = "P";
            8'b100_00111: w_decoded = "J";
            8'b100_01000: w_decoded = "B";
            8'b100_01001: w_decoded = "X";
            8'b100_01010: w_decoded = "C";
            8'b100_01011: w_decoded = "Y";
            8'b100_01100: w_decoded = "Z";
            8'b100_01101: w_decoded = "Q";
            8'b101_00000: w_decoded = "5";
            8'b101_00001: w_decoded = "4";
            8'b101_00011: w_decoded = "3";
            8'b101_00111: w_decoded = "2";
            8'b101_01111: w_decoded = "1";
            8'b101_10000: w_decoded = "6";
            8'b101_11000: w_decoded = "7";
            8'b101_11100: w_decoded = "8";
            8'b101_11110: w_decoded = "9";
            8'b101_11111: w_decoded = "0";
            default:      w_decoded = UNKNOWN_CHAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pattern    <= 5'd0;
            r_sym_len    <= 3'd0;
            r_last_space <= 1'b1;
            r_pend_space <= 1'b0;
        end else begin
            if (r_pend_space) begin
                r_pend_space <= 1'b0;
                r_last_space <= 1'b1;
            end
            if (w_iw) begin
                r_pend_space <= w_char_push | ~r_last_space;
            end
            if (w_char_push) begin
                r_state      <= S_IDLE;
                r_pattern    <= 5'd0;
                r_sym_len    <= 3'd0;
                r_last_space <= 1'b0;
            end else if (w_sym && r_state != S_ERR) begin
                if (r_sym_len == 3'd5) begin
                    r_state <= S_ERR;
                end else begin
                    r_state   <= S_COLLECT;
                    r_pattern <= {r_pattern[3:0], dash};
                    r_sym_len <= r_sym_len + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) r_overflow <= 1'b1;
        end
    end

    assign empty    = (r_count == 3'd0);
    assign full     = (r_count == DEPTH);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign sym_len  = r_sym_len;
    assign char_out = empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed scenarios plus random pulses, checked against
// a string/queue model that decodes by looking the dot-dash text up in a Morse table.
module tb_morse_decoder;
    logic       clk = 1'b0;
    logic       reset, dot, dash, interchar, interword, rd_en;
    logic [7:0] char_out;
    logic       empty, full, overflow;
    logic [2:0] count, sym_len;

    int n_cmp = 0;
    int n_err = 0;

    morse_decoder dut (
        .clk(clk), .reset(reset), .dot(dot), .dash(dash),
        .interchar(interchar), .interword(interword), .rd_en(rd_en),
        .char_out(char_out), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .sym_len(sym_len)
    );

    always #5 clk = ~clk;

    string      codes [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."};

    string      m_sym;
    bit         m_err, m_last_space, m_pend, m_ovf;
    logic [7:0] m_q [$];

    function automatic logic [7:0] lookup(input string s);
        for (int i = 0; i < 36; i++)
            if (codes[i] == s) return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        return 8'h3F;
    endfunction

    task automatic model_reset();
        m_sym = ""; m_err = 0; m_last_space = 1; m_pend = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit d, input bit da, input bit ic, input bit iw, input bit rd);
        bit         iwe, ice, syme, do_push, popped;
        logic [7:0] pv;
        iwe = iw && !m_pend;
        ice = ic && !iw && !m_pend;
        syme = (d || da) && !iwe && !ice;
        do_push = 0;
        pv = 8'h00;
        if (m_pend) begin
            do_push = 1; pv = 8'h20; m_pend = 0; m_last_space = 1;
        end else if ((iwe || ice) && (m_err || m_sym.len() > 0)) begin
            do_push = 1; pv = m_err ? 8'h3F : lookup(m_sym);
            m_sym = ""; m_err = 0; m_last_space = 0;
        end
        if (iwe && !m_last_space) m_pend = 1;
        if (syme && !m_err) begin
            if (m_sym.len() == 5) m_err = 1;
            else m_sym = {m_sym, da ? "-" : "."};
        end
        popped = rd && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < 4) m_q.push_back(pv);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("char_out", char_out, (m_q.size() > 0) ? m_q[0] : 8'h00);
        chk("count", 8'(count), 8'(m_q.size()));
        chk("empty", 8'(empty), 8'(m_q.size() == 0));
        chk("full", 8'(full), 8'(m_q.size() == 4));
        chk("overflow", 8'(overflow), 8'(m_ovf));
        chk("sym_len", 8'(sym_len), 8'(m_err ? 5 : m_sym.len()));
    endtask

    task automatic step(input bit d, input bit da, input bit ic, input bit iw, input bit rd,
                        input bit rst = 0);
        reset = rst; dot = d; dash = da; interchar = ic; interword = iw; rd_en = rd;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(d, da, ic, iw, rd);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1; dot = 0; dash = 0; interchar = 0; interword = 0; rd_en = 0;
        model_reset();
        do_reset();
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_char", char_out, 8'h00);

        // A
        step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
        chk("A_char", char_out, 8'h41);
        chk("A_count", 8'(count), 8'd1);
        chk("A_symlen", 8'(sym_len), 8'd0);

        // 0 then space, second word gap adds nothing
        do_reset();
        repeat (5) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("zero_head", char_out, 8'h30);
        chk("zero_count", 8'(count), 8'd2);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("iw2_count", 8'(count), 8'd2);
        step(0, 0, 0, 0, 1);
        chk("space_head", char_out, 8'h20);

        // six dots -> unknown
        do_reset();
        repeat (6) step(1, 0, 0, 0, 0);
        chk("err_symlen", 8'(sym_len), 8'd5);
        step(0, 0, 1, 0, 0);
        chk("err_char", char_out, 8'h3F);
        chk("err_symlen0", 8'(sym_len), 8'd0);

        // overflow then push+pop at full
        do_reset();
        for (int i = 0; i < 5; i++) begin step(i == 0, i != 0, 0, 0, 0); step(0, 0, 1, 0, 0); end
        chk("ovf_count", 8'(count), 8'd4);
        chk("ovf_full", 8'(full), 8'd1);
        chk("ovf_flag", 8'(overflow), 8'd1);
        chk("ovf_head", char_out, 8'h45);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        chk("pp_count", 8'(count), 8'd4);
        chk("pp_head", char_out, 8'h54);

        // reset mid-character
        do_reset();
        step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("midrst_empty", 8'(empty), 8'd1);

        // dot coincident with interchar is dropped
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("E_char", char_out, 8'h45);
        chk("E_symlen", 8'(sym_len), 8'd0);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int rdp;
            rdp = (c < 2000) ? 8 : 45;
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < rdp, $urandom_range(0, 999) < 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
